smix_scratchpad_ctrl: RTL and testbench
=======================================

# smix_scratchpad_ctrl

Parametrised scratchpad controller for the SMIX core: stores the N-entry V array during the sequential fill loop, then serves random-index reads during the mix loop. It owns its storage (an inferred synchronous RAM), sequences the two SMIX phases with a small state machine, and presents valid/ready handshakes to the SMIX datapath. It replaces the fixed-size, handshake-free scratchpad wrapper with a sized, self-counting block.

## Interface
- WORD_W, 1024: bits per scratchpad entry (one 128-byte scrypt block).
- LOG_N, 10: log2 of entry count N; address width is LOG_N.
- IDX_W, 32: width of the incoming Integerify index.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart: return to FILL, zero all counters.
- wr_valid  in  1  fill write request.
- wr_ready  out  1  fill write accepted when high with wr_valid.
- wr_data  in  WORD_W  entry written at the current fill pointer.
- rd_valid  in  1  mix read request.
- rd_ready  out  1  mix read accepted when high with rd_valid.
- rd_index  in  IDX_W  Integerify value; entry address = rd_index[LOG_N-1:0].
- rd_data  out  WORD_W  registered read data.
- rd_data_valid  out  1  one-cycle pulse, rd_data is new.
- fill_count  out  LOG_N+1  entries written since reset/clear.
- mix_count  out  LOG_N+1  reads accepted since entering MIX.
- phase  out  2  00 FILL, 01 MIX, 10 DONE.
- par_inject  in  1  flip stored parity of this write (test only; ignored without macro).
- par_err  out  1  parity mismatch, pulses with rd_data_valid.

## Operation
- States: FILL -> MIX -> DONE. Reset and clear enter FILL.
- FILL: wr_ready = 1, rd_ready = 0. Each accepted write stores wr_data at address fill_count[LOG_N-1:0], fill_count += 1. The write that brings fill_count to N moves the state to MIX on the same edge.
- MIX: wr_ready = 0, rd_ready = 1. Each accepted read latches address = rd_index mod N and increments mix_count. Reads are fully pipelined: one per cycle, no back-pressure. The read that brings mix_count to N moves the state to DONE.
- DONE: wr_ready = rd_ready = 0. Counters hold at N. Reads already in flight still complete.
- wr_valid in MIX/DONE and rd_valid in FILL/DONE are ignored: no state change, no counter change, no rd_data_valid.
- clear has priority over every request in the same cycle. The write or read is dropped, and an in-flight read is squashed (rd_data_valid stays 0 next cycle).
- rd_data holds its last value until the next read completes. Reset and clear zero it.
- Counters never wrap; fill_count and mix_count saturate at N by construction.

## Timing
- Reset values: wr_ready 0 during the rst cycle, then 1. rd_ready 0, rd_data 0, rd_data_valid 0, fill_count 0, mix_count 0, phase 00, par_err 0.
- Write: accepted on edge k, visible to a read accepted on edge k+1 or later.
- Read latency 1: request accepted on edge k; rd_data/rd_data_valid are valid after edge k+1.
- phase and the ready flags change on the edge of the final accepted transfer. The first MIX read can be accepted on the cycle after the last fill write.
- rst asserted mid-operation: all state returns to reset values on that edge, and in-flight reads are discarded. RAM contents are not cleared and are undefined to the user.

## Configuration
- SMIX_SCRATCH_PARITY_EN defined: each entry stores one extra even-parity bit computed over wr_data. When par_inject is high, the stored bit is inverted. On a read, parity is recomputed and par_err pulses with rd_data_valid on mismatch. Data is still returned unchanged.
- Not defined: no parity storage (RAM is WORD_W wide), par_inject is ignored, and par_err is tied 0.

## Test plan
All scenarios use LOG_N = 3 (N = 8) and WORD_W = 1024.
- Reset, then idle 3 cycles -> phase 00, wr_ready 1, rd_ready 0, fill_count 0, rd_data 0.
- 8 back-to-back writes of data = i*0x1111 -> fill_count 8, phase 01 after the 8th edge, rd_ready 1 the next cycle.
- After the fill, reads with rd_index 0x0000000D, 0xFFFFFFF8, 3 in consecutive cycles -> rd_data = entry 5, entry 0, entry 3 on three consecutive cycles, one cycle after each request.
- 8 reads -> phase 10 and mix_count 8. A 9th rd_valid produces no rd_data_valid. wr_valid during MIX leaves fill_count unchanged.
- clear asserted in the same cycle as a MIX read -> no rd_data_valid next cycle, phase 00, counters 0, rd_data 0. rst mid-FILL at fill_count 5 -> fill_count 0.
- Macro defined: write entry 2 with par_inject = 1, then read index 2 -> par_err = 1 with rd_data_valid and data intact. Read any clean entry -> par_err 0. Macro undefined: same stimulus -> par_err stays 0.

Source files
------------

// File: rtl/smix_scratchpad_ctrl.sv
// ============================================================================
// Module   : smix_scratchpad_ctrl
// Purpose  : SMIX V-array scratchpad: sequential fill, then random-index mix
//            reads with valid/ready handshakes. Optional per-entry parity
//            storage is enabled by defining SMIX_SCRATCH_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smix_scratchpad_ctrl #(
    parameter int WORD_W = 1024,
    parameter int LOG_N  = 10,
    parameter int IDX_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic [LOG_N:0]    fill_count,
    output logic [LOG_N:0]    mix_count,
    output logic [1:0]        phase,
    input  logic              par_inject,
    output logic              par_err
);

    localparam logic [LOG_N:0] c_LAST = {1'b0, {LOG_N{1'b1}}};
    localparam logic [LOG_N:0] c_ONE  = {{LOG_N{1'b0}}, 1'b1};
`ifdef SMIX_SCRATCH_PARITY_EN
    localparam int c_MEM_W = WORD_W + 1;
`else
    localparam int c_MEM_W = WORD_W;
`endif

    typedef enum logic [1:0] {
        ST_FILL = 2'b00,
        ST_MIX  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_wr_ready;
    logic                r_rd_ready;
    logic [LOG_N:0]      r_fill_count;
    logic [LOG_N:0]      r_mix_count;
    logic [LOG_N-1:0]    r_rd_addr;
    logic                r_rd_pend;
    logic [WORD_W-1:0]   r_rd_data;
    logic                r_rd_data_valid;
    logic                r_par_err;
    logic [c_MEM_W-1:0]  r_mem [0:(1<<LOG_N)-1];

    logic [c_MEM_W-1:0]  w_wr_word;
    logic [c_MEM_W-1:0]  w_rd_word;
    logic                w_par_bad;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic [IDX_W-LOG_N-1:0] w_unused_idx;

    // Only the low LOG_N bits of the Integerify value select the entry.
    assign w_unused_idx = rd_index[IDX_W-1:LOG_N];

    assign w_wr_fire = wr_valid & r_wr_ready & ~clear & ~rst;
    assign w_rd_fire = rd_valid & r_rd_ready & ~clear & ~rst;
    assign w_rd_word = r_mem[r_rd_addr];

`ifdef SMIX_SCRATCH_PARITY_EN
    // Stored bit makes the whole entry even; a clean entry XORs to zero.
    assign w_wr_word = {(^wr_data) ^ par_inject, wr_data};
    assign w_par_bad = ^w_rd_word;
`else
    logic w_unused_par;
    assign w_unused_par = par_inject;
    assign w_wr_word    = wr_data;
    assign w_par_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_fill_count[LOG_N-1:0]] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state         <= ST_FILL;
            r_wr_ready      <= 1'b1;
            r_rd_ready      <= 1'b0;
            r_fill_count    <= '0;
            r_mix_count     <= '0;
            r_rd_addr       <= '0;
            r_rd_pend       <= 1'b0;
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
            r_par_err       <= 1'b0;
        end else begin
            r_rd_data_valid <= r_rd_pend;
            r_par_err       <= r_rd_pend & w_par_bad;
            r_rd_pend       <= 1'b0;
            if (r_rd_pend) begin
                r_rd_data <= w_rd_word[WORD_W-1:0];
            end
            case (r_state)
                ST_FILL: begin
                    if (w_wr_fire) begin
                        r_fill_count <= r_fill_count + c_ONE;
                        if (r_fill_count == c_LAST) begin
                            r_state    <= ST_MIX;
                            r_wr_ready <= 1'b0;
                            r_rd_ready <= 1'b1;
                        end
                    end
                end
                ST_MIX: begin
                    if (w_rd_fire) begin
                        r_rd_pend   <= 1'b1;
                        r_rd_addr   <= rd_index[LOG_N-1:0];
                        r_mix_count <= r_mix_count + c_ONE;
                        if (r_mix_count == c_LAST) begin
                            r_state    <= ST_DONE;
                            r_rd_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // wr_ready must read low while rst is held, even before the first edge.
    assign wr_ready      = r_wr_ready & ~rst;
    assign rd_ready      = r_rd_ready;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;
    assign fill_count    = r_fill_count;
    assign mix_count     = r_mix_count;
    assign phase         = r_state;
    assign par_err       = r_par_err;

endmodule

`default_nettype wire

// File: tb/tb_smix_scratchpad_ctrl.sv
// ============================================================================
// Module   : tb_smix_scratchpad_ctrl
// Purpose  : Directed + randomized bench for smix_scratchpad_ctrl (N = 8)
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smix_scratchpad_ctrl;

    localparam int WORD_W = 1024;
    localparam int LOG_N  = 3;
    localparam int IDX_W  = 32;
    localparam int N      = 8;

    logic              clk = 1'b0;
    logic              rst, clear, wr_valid, rd_valid, par_inject;
    logic [WORD_W-1:0] wr_data;
    logic [IDX_W-1:0]  rd_index;
    logic              wr_ready, rd_ready, rd_data_valid, par_err;
    logic [WORD_W-1:0] rd_data;
    logic [LOG_N:0]    fill_count, mix_count;
    logic [1:0]        phase;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int                m_phase, m_fill, m_mix;
    logic [WORD_W-1:0] m_mem [N];
    bit                m_inj [N];
    bit                m_pend, m_pend_inj, m_rdv, m_perr;
    logic [WORD_W-1:0] m_pend_data, m_rd_data;

    smix_scratchpad_ctrl #(.WORD_W(WORD_W), .LOG_N(LOG_N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_index(rd_index),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .fill_count(fill_count), .mix_count(mix_count), .phase(phase),
        .par_inject(par_inject), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WORD_W-1:0] got,
                             input logic [WORD_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (low 96 bits) t=%0t",
                     tag, got[95:0], exp[95:0], $time);
        end
    endtask

    task automatic model_edge();
        int a;
        if (rst || clear) begin
            m_phase = 0; m_fill = 0; m_mix = 0;
            m_pend = 0; m_rdv = 0; m_perr = 0; m_rd_data = '0;
        end else begin
            m_rdv = m_pend;
`ifdef SMIX_SCRATCH_PARITY_EN
            m_perr = m_pend && m_pend_inj;
`else
            m_perr = 0;
`endif
            if (m_pend) m_rd_data = m_pend_data;
            m_pend = 0;
            if (m_phase == 0 && wr_valid) begin
                m_mem[m_fill] = wr_data;
                m_inj[m_fill] = par_inject;
                m_fill++;
                if (m_fill == N) m_phase = 1;
            end else if (m_phase == 1 && rd_valid) begin
                a = int'(rd_index % N);
                m_pend = 1;
                m_pend_data = m_mem[a];
                m_pend_inj  = m_inj[a];
                m_mix++;
                if (m_mix == N) m_phase = 2;
            end
        end
    endtask

    task automatic check_all();
        check_val("phase",         WORD_W'(phase),         WORD_W'(m_phase));
        check_val("fill_count",    WORD_W'(fill_count),    WORD_W'(m_fill));
        check_val("mix_count",     WORD_W'(mix_count),     WORD_W'(m_mix));
        check_val("wr_ready",      WORD_W'(wr_ready),      WORD_W'((m_phase == 0) && !rst));
        check_val("rd_ready",      WORD_W'(rd_ready),      WORD_W'(m_phase == 1));
        check_val("rd_data_valid", WORD_W'(rd_data_valid), WORD_W'(m_rdv));
        check_val("rd_data",       rd_data,                m_rd_data);
        check_val("par_err",       WORD_W'(par_err),       WORD_W'(m_perr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        rst = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        par_inject = 1'b0; rd_index = '0;
    endtask

    task automatic rand_word(output logic [WORD_W-1:0] w);
        for (int k = 0; k < WORD_W / 32; k++) w[k*32 +: 32] = $urandom;
    endtask

    task automatic do_fill(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wr_valid = 1'b1;
            rand_word(wr_data);
            step();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        wr_data = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

        // Fill with i*0x1111, corrupting the parity of entry 2.
        for (int i = 0; i < N; i++) begin
            wr_valid   = 1'b1;
            wr_data    = WORD_W'(i * 32'h1111);
            par_inject = (i == 2);
            step();
        end
        set_idle();
        step();

        rd_valid = 1'b1;
        rd_index = 32'h0000_000D; step();
        rd_index = 32'hFFFF_FFF8; step();
        rd_index = 32'd3;         step();
        rd_valid = 1'b0;
        wr_valid = 1'b1; rand_word(wr_data); step();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_index = 32'd2; step();
        for (int i = 0; i < 4; i++) begin
            rd_index = $urandom;
            step();
        end
        rd_index = 32'd6; step();
        set_idle();
        repeat (3) step();

        // clear in the same cycle as a MIX read
        do_fill(N);
        step();
        rd_valid = 1'b1; rd_index = 32'd4; step();
        rd_index = 32'd5; clear = 1'b1; step();
        set_idle();
        repeat (2) step();

        // clear squashing a read already accepted
        do_fill(N);
        rd_valid = 1'b1; rd_index = 32'd1; step();
        rd_valid = 1'b0; clear = 1'b1; step();
        set_idle();
        step();

        // rst mid-FILL at fill_count 5
        do_fill(5);
        rst = 1'b1; step();
        rst = 1'b0; step();

        repeat (3000) begin
            rst        = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 59) == 0);
            wr_valid   = ($urandom_range(0, 3) != 0);
            rd_valid   = ($urandom_range(0, 3) != 0);
            par_inject = ($urandom_range(0, 7) == 0);
            rd_index   = $urandom;
            rand_word(wr_data);
            step();
        end
        set_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
